// File: rtl/coeff_pkg.sv
// Shared definitions for the coefficient bank: controller states and slot count.
package coeff_pkg;

  localparam int NUM_COEFFS = 4;
  localparam int IDX_WIDTH  = $clog2(NUM_COEFFS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SETTLE  = 2'd2
  } state_t;

endpackage

// File: rtl/coefficient_bank_ctrl.sv
// Handshake controller: accepts one load request at a time, stalls the commit
// while the datapath is reading, and holds modwait for the whole transaction.
module coefficient_bank_ctrl
  import coeff_pkg::*;
(
  input  logic clk_i,
  input  logic n_reset_i,
  input  logic load_coeff_i,
  input  logic fir_busy_i,
  output logic modwait_o,
  output logic accept_o,
  output logic commit_o,
  output logic overrun_evt_o
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    accept_o      = 1'b0;
    commit_o      = 1'b0;
    overrun_evt_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_coeff_i) begin
          accept_o = 1'b1;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        overrun_evt_o = load_coeff_i;
        if (!fir_busy_i) begin
          commit_o = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        overrun_evt_o = load_coeff_i;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore decode so modwait never depends combinationally on an input.
  assign modwait_o = (state_q != IDLE);

endmodule

// File: rtl/coefficient_bank.sv
// Four-slot coefficient store written one slot at a time by an external loader,
// with per-slot valid tracking, a set-complete pulse and a sticky overrun flag.
module coefficient_bank
  import coeff_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  load_coeff,
  input  logic [IDX_WIDTH-1:0]  coefficient_num,
  input  logic [DATA_WIDTH-1:0] coeff_data,
  input  logic                  fir_busy,
  input  logic                  clear_set,
  output logic                  modwait,
  output logic [DATA_WIDTH-1:0] f0_coeff,
  output logic [DATA_WIDTH-1:0] f1_coeff,
  output logic [DATA_WIDTH-1:0] f2_coeff,
  output logic [DATA_WIDTH-1:0] f3_coeff,
  output logic [NUM_COEFFS-1:0] coeff_valid,
  output logic                  set_complete,
  output logic                  overrun
);

  logic accept;
  logic commit;
  logic overrun_evt;

  coefficient_bank_ctrl u_ctrl (
    .clk_i        (clk),
    .n_reset_i    (n_reset),
    .load_coeff_i (load_coeff),
    .fir_busy_i   (fir_busy),
    .modwait_o    (modwait),
    .accept_o     (accept),
    .commit_o     (commit),
    .overrun_evt_o(overrun_evt)
  );

  logic [IDX_WIDTH-1:0]  pend_num_q,  pend_num_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic [DATA_WIDTH-1:0] coeff_q [NUM_COEFFS];
  logic [DATA_WIDTH-1:0] coeff_d [NUM_COEFFS];
  logic [NUM_COEFFS-1:0] valid_q, valid_d;
  logic                  set_complete_q, set_complete_d;
  logic                  overrun_q, overrun_d;

  // Clear is applied before the commit so a coincident write survives the clear.
  always_comb begin
    pend_num_d  = pend_num_q;
    pend_data_d = pend_data_q;
    coeff_d     = coeff_q;
    valid_d     = clear_set ? '0 : valid_q;
    if (accept) begin
      pend_num_d  = coefficient_num;
      pend_data_d = coeff_data;
    end
    if (commit) begin
      coeff_d[pend_num_q] = pend_data_q;
      valid_d[pend_num_q] = 1'b1;
    end
    set_complete_d = commit && (&valid_d) && !(&valid_q);
    overrun_d      = (clear_set ? 1'b0 : overrun_q) | overrun_evt;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pend_num_q     <= '0;
      pend_data_q    <= '0;
      for (int i = 0; i < NUM_COEFFS; i++) begin
        coeff_q[i] <= '0;
      end
      valid_q        <= '0;
      set_complete_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      pend_num_q     <= pend_num_d;
      pend_data_q    <= pend_data_d;
      coeff_q        <= coeff_d;
      valid_q        <= valid_d;
      set_complete_q <= set_complete_d;
      overrun_q      <= overrun_d;
    end
  end

  assign f0_coeff     = coeff_q[0];
  assign f1_coeff     = coeff_q[1];
  assign f2_coeff     = coeff_q[2];
  assign f3_coeff     = coeff_q[3];
  assign coeff_valid  = valid_q;
  assign set_complete = set_complete_q;
  assign overrun      = overrun_q;

endmodule
